// File: rtl/aesl_deadlock_detect_unit.sv
// ============================================================================
// aesl_deadlock_detect_unit: per-process stall/reach tracker and report-token relay.
// Optional trace output when DEADLOCK_TRACE_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module aesl_deadlock_detect_unit #(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int STALL_THRESH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         proc_blocked,
  input  logic [PROC_NUM-1:0]          wait_vec,
  input  logic [PROC_NUM*PROC_NUM-1:0] reach_in,
  output logic [PROC_NUM-1:0]          reach_out,
  input  logic [PROC_NUM*PROC_NUM-1:0] token_vec_in,
  output logic [PROC_NUM-1:0]          token_out,
  input  logic [PROC_NUM-1:0]          origin,
  input  logic                         token_clear,
  input  logic                         dl_detect_in,
  output logic                         dl_out
);

  localparam int CNT_W = $clog2(STALL_THRESH + 1);
  localparam int HOP_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_THRESH);

  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [PROC_NUM-1:0] reach_q, reach_d;
  logic [PROC_NUM-1:0] token_q, token_d;
  logic                holding;
  logic                hop_found;
  logic [HOP_W-1:0]    next_hop;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!dl_detect_in) begin
      if (!proc_blocked)
        stall_cnt_d = '0;
      else if (stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Transitive wait set: everything each waited-on process reaches, plus that process itself.
  always_comb begin
    reach_d = '0;
    if (proc_blocked) begin
      for (int j = 0; j < PROC_NUM; j++) begin
        if (wait_vec[j])
          reach_d = reach_d | reach_in[j*PROC_NUM +: PROC_NUM] | (PROC_NUM'(1) << j);
      end
    end
  end

  always_comb begin
    holding = 1'b0;
    for (int j = 0; j < PROC_NUM; j++)
      holding = holding | token_vec_in[j*PROC_NUM + PROC_ID];
  end

  // Lowest waited-on process that leads back to us; descending scan so the lowest wins.
  always_comb begin
    hop_found = 1'b0;
    next_hop  = '0;
    for (int j = PROC_NUM - 1; j >= 0; j--) begin
      if (wait_vec[j] && reach_in[j*PROC_NUM + PROC_ID]) begin
        hop_found = 1'b1;
        next_hop  = HOP_W'(j);
      end
    end
  end

  always_comb begin
    token_d = '0;
    if ((origin[PROC_ID] || holding) && !token_clear && hop_found)
      token_d = PROC_NUM'(1) << next_hop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      reach_q     <= '0;
      token_q     <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      reach_q     <= reach_d;
      token_q     <= token_d;
    end
  end

  assign reach_out = reach_q;
  assign token_out = token_q;
  assign dl_out    = dl_detect_in ? holding
                                  : ((stall_cnt_q == CNT_MAX) && reach_q[PROC_ID] && proc_blocked);

`ifdef DEADLOCK_TRACE_EN
  logic dl_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dl_prev_q <= 1'b0;
    else        dl_prev_q <= dl_out;
  end

  always @(posedge clock) begin
    if (reset && (token_d != '0))
      $display("// trace: proc %0d -> proc %0d @ %0t ns", PROC_ID, next_hop, $time);
    if (reset && !dl_detect_in && dl_out && !dl_prev_q)
      $display("// trace: proc %0d deadlock detected, reach_out=%b", PROC_ID, reach_q);
  end
`endif

endmodule

`default_nettype wire
